// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: word size, default latency and FSM states shared by the responder
package mem_responder_pkg;
    localparam int WORD_SIZE   = 16;
    localparam int MEM_LATENCY = 2;
    typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: unreset word storage with synchronous write and registered read
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int W      = WORD_SIZE
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [W-1:0]      i_wdata,
    output logic [W-1:0]      o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding CPU memory port responder with fixed latency
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    output logic                 ackOutput,
    output logic                 protocol_err
);
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [WORD_SIZE-1:0] r_wdata, w_wdata, w_rdata;
    logic r_rd, r_err, w_rd, w_err, w_go, w_held, w_unused;
    assign w_unused = &{1'b0, address[WORD_SIZE-1:ADDR_W]};
    // with zero latency the array is accessed on the sampling edge, straight from the inputs
    assign w_rd    = (r_state == IDLE) ? readM : r_rd;
    assign w_addr  = (r_state == IDLE) ? address[ADDR_W-1:0] : r_addr;
    assign w_wdata = (r_state == IDLE) ? data : r_wdata;
    assign w_held  = r_rd ? readM : writeM;
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_err  = r_err;
        w_go   = 1'b0;
        case (r_state)
            IDLE: begin
                if (readM && writeM) begin
                    w_err = 1'b1;
                end else if (readM ^ writeM) begin
                    w_next = (LATENCY == 0) ? RESP : BUSY;
                    w_go   = (LATENCY == 0);
                    w_cnt  = CW'(LATENCY);
                end
            end
            BUSY: begin
                if (!w_held) begin
                    w_err  = 1'b1;
                    w_next = IDLE;
                    w_cnt  = '0;
                end else if (r_cnt == CW'(1)) begin
                    w_next = RESP;
                    w_go   = 1'b1;
                    w_cnt  = '0;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            RESP:    w_next = RELEASE;
            RELEASE: w_next = (!readM && !writeM) ? IDLE : RELEASE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_err   <= w_err;
            if (r_state == IDLE && (readM ^ writeM)) begin
                r_rd    <= readM;
                r_addr  <= address[ADDR_W-1:0];
                r_wdata <= data;
            end
        end
    end
    mem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(WORD_SIZE)) u_array (
        .clk     (clk),
        .i_we    (w_go & ~w_rd),
        .i_re    (w_go & w_rd),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );
    assign inputReady   = (r_state == RESP) && r_rd;
    assign ackOutput    = (r_state == RESP) && !r_rd;
    assign protocol_err = r_err;
    assign data         = inputReady ? w_rdata : 'z;
endmodule
